// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types and constants for the seven-segment scan driver
package seg_pkg;

   localparam int NUM_DIGITS = 4;
   localparam logic [3:0] AN_ALL_OFF = 4'b1111;

   // Digit slot currently being scanned; DIG0 is the rightmost digit.
   typedef enum logic [1:0] {
      DIG0 = 2'd0,
      DIG1 = 2'd1,
      DIG2 = 2'd2,
      DIG3 = 2'd3
   } digit_t;

   // One hex digit, as consumed by the hex-to-seven-segment decoder.
   typedef logic [3:0] nibble_t;

   // Active-low anode pattern that lights exactly one digit.
   function automatic logic [3:0] anode_for(input digit_t d);
      return ~(4'b0001 << d);
   endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// rtl/scan_tick_gen.sv - per-slot prescaler producing the digit slot wrap
module scan_tick_gen #(
   parameter int REFRESH_DIV = 100000,
   parameter int CNT_W       = $clog2(REFRESH_DIV)
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [CNT_W-1:0] tick_cnt,
   output logic             slot_wrap
);

   localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(REFRESH_DIV - 1);

   assign slot_wrap = (tick_cnt == LAST_TICK);

   // Count 0..REFRESH_DIV-1 and wrap, giving an exact, drift-free slot length.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt <= '0;
      end else if (slot_wrap) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - 4-digit common-anode scan driver with blanking and shadowed input
module seg_scan_mux
   import seg_pkg::*;
#(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] value,
   input  logic [3:0]  digit_en,
   input  logic        lz_blank,
   output logic [3:0]  nibble,
   output logic [3:0]  an,
   output logic        frame_start
);

   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0] BLANK_LIMIT = CNT_W'(BLANK_CYCLES);

   logic [CNT_W-1:0] tick_cnt;
   logic             slot_wrap;

   digit_t           digit_sel;
   digit_t           digit_nxt;

   logic [15:0]      shadow_val;
   logic [3:0]       shadow_en;
   logic             shadow_lz;

   logic             frame_bound;
   logic             blank_phase;
   logic [3:0]       upper_zero;
   logic             suppress;
   nibble_t          cur_nibble;
   logic [3:0]       an_nxt;

   scan_tick_gen #(
      .REFRESH_DIV (REFRESH_DIV),
      .CNT_W       (CNT_W)
   ) u_tick (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick_cnt  (tick_cnt),
      .slot_wrap (slot_wrap)
   );

   // Slot 0 at tick 0 is the frame boundary; it is also the first cycle after reset.
   assign frame_bound = (digit_sel == DIG0) && (tick_cnt == '0);
   assign blank_phase = (tick_cnt < BLANK_LIMIT);

   // Digit state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit_sel <= DIG0;
      end else begin
         digit_sel <= digit_nxt;
      end
   end

   // Advance to the next digit only when the prescaler wraps.
   always_comb begin
      digit_nxt = digit_sel;
      if (slot_wrap) begin
         case (digit_sel)
            DIG0:    digit_nxt = DIG1;
            DIG1:    digit_nxt = DIG2;
            DIG2:    digit_nxt = DIG3;
            DIG3:    digit_nxt = DIG0;
            default: digit_nxt = DIG0;
         endcase
      end
   end

   // Capture inputs once per frame so a mid-frame change never tears the display.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_val <= 16'h0000;
         shadow_en  <= 4'h0;
         shadow_lz  <= 1'b0;
      end else if (frame_bound) begin
         shadow_val <= value;
         shadow_en  <= digit_en;
         shadow_lz  <= lz_blank;
      end
   end

   // Leading-zero detection and per-slot nibble/anode selection.
   always_comb begin
      upper_zero    = 4'b0000;
      upper_zero[3] = (shadow_val[15:12] == 4'h0);
      upper_zero[2] = upper_zero[3] && (shadow_val[11:8] == 4'h0);
      upper_zero[1] = upper_zero[2] && (shadow_val[7:4]  == 4'h0);
      // Digit 0 always shows, so an all-zero value still reads "0".
      upper_zero[0] = 1'b0;

      suppress = shadow_lz && upper_zero[digit_sel];

      case (digit_sel)
         DIG0:    cur_nibble = shadow_val[3:0];
         DIG1:    cur_nibble = shadow_val[7:4];
         DIG2:    cur_nibble = shadow_val[11:8];
         DIG3:    cur_nibble = shadow_val[15:12];
         default: cur_nibble = shadow_val[3:0];
      endcase

      if (blank_phase || !shadow_en[digit_sel] || suppress) begin
         an_nxt = AN_ALL_OFF;
      end else begin
         an_nxt = anode_for(digit_sel);
      end
   end

   // Registered outputs; anodes drop to all-off immediately on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nibble      <= 4'h0;
         an          <= AN_ALL_OFF;
         frame_start <= 1'b0;
      end else begin
         nibble      <= cur_nibble;
         an          <= an_nxt;
         frame_start <= frame_bound;
      end
   end

endmodule
